// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: Coprocessor-0 interrupt controller for the pipelined MIPS core.
// Holds Status/Cause/EPC/PRId, decides when a hardware interrupt is taken,
// drives the one-cycle pcint redirect and tracks eret to leave the handler.
// Optional feature macro: CP0_COUNT_EN adds the Count (9) / Compare (11) timer,
// whose sticky match flag is ORed into Cause.IP7.
module cp0_int_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h00003008,
    parameter logic [31:0] PRID_VAL     = 32'h00018000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic [31:0] cur_pc,
    input  logic        pc_valid,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret,
    output logic [31:0] cp0_rdata,
    output logic        pcint,
    output logic [31:0] epc,
    output logic        exl,
    output logic [31:0] int_vector
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_TAKE,
        S_HANDLER
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic [5:0]  cause_ip_hw;
    logic [5:0]  cause_ip;
    logic [31:0] epc_q;
    logic        irq;
    logic        take_entry;

    wire         wr_status = cp0_we && (cp0_addr == REG_STATUS);
    wire         wr_epc    = cp0_we && (cp0_addr == REG_EPC);

`ifdef CP0_COUNT_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        timer_flag;
    logic        timer_hit;

    wire         wr_count   = cp0_we && (cp0_addr == REG_COUNT);
    wire         wr_compare = cp0_we && (cp0_addr == REG_COMPARE);

    // A zero Compare disables the timer; a live match is visible in the
    // same cycle so the interrupt is taken the cycle after Count hits Compare.
    assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);
    assign cause_ip  = {cause_ip_hw[5] | timer_flag | timer_hit, cause_ip_hw[4:0]};

    // Free-running Count, software Compare and the sticky timer flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            timer_flag <= 1'b0;
        end else begin
            count_q <= wr_count ? cp0_wdata : count_q + 32'd1;
            if (wr_compare) begin
                compare_q  <= cp0_wdata;
                timer_flag <= 1'b0;
            end else if (timer_hit) begin
                timer_flag <= 1'b1;
            end
        end
    end
`else
    assign cause_ip = cause_ip_hw;
`endif

    assign irq        = (|(cause_ip & status_im)) & status_ie & ~status_exl;
    assign pcint      = (state == S_TAKE);
    assign epc        = epc_q;
    assign exl        = status_exl;
    assign int_vector = HANDLER_ADDR;

    // Interrupt sequencing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; take_entry marks the edge that enters TAKE.
    always_comb begin
        state_next = state;
        take_entry = 1'b0;
        case (state)
            S_RUN: begin
                if (irq) begin
                    if (pc_valid) begin
                        state_next = S_TAKE;
                        take_entry = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!irq) begin
                    state_next = S_RUN;
                end else if (pc_valid) begin
                    state_next = S_TAKE;
                    take_entry = 1'b1;
                end
            end
            S_TAKE: begin
                state_next = S_HANDLER;
            end
            S_HANDLER: begin
                if (eret) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // Status: software write first, eret clears EXL, interrupt entry forces EXL.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_im  <= 6'd0;
            status_ie  <= 1'b0;
            status_exl <= 1'b0;
        end else begin
            if (wr_status) begin
                status_im  <= cp0_wdata[15:10];
                status_ie  <= cp0_wdata[0];
                status_exl <= cp0_wdata[1];
            end
            if (eret) begin
                status_exl <= 1'b0;
            end
            if (take_entry) begin
                status_exl <= 1'b1;
            end
        end
    end

    // Cause.IP samples the external lines every cycle; software cannot write it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_ip_hw <= 6'd0;
        end else begin
            cause_ip_hw <= hw_int;
        end
    end

    // EPC: the interrupted PC has priority over a simultaneous mtc0.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= 32'd0;
        end else if (take_entry) begin
            epc_q <= cur_pc;
        end else if (wr_epc) begin
            epc_q <= cp0_wdata;
        end
    end

    // mfc0 read mux; returns pre-write register contents (no bypass).
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            REG_STATUS: cp0_rdata = {16'd0, status_im, 8'd0, status_exl, status_ie};
            REG_CAUSE:  cp0_rdata = {16'd0, cause_ip, 10'd0};
            REG_EPC:    cp0_rdata = epc_q;
            REG_PRID:   cp0_rdata = PRID_VAL;
`ifdef CP0_COUNT_EN
            REG_COUNT:   cp0_rdata = count_q;
            REG_COMPARE: cp0_rdata = compare_q;
`endif
            default:    cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Testbench for cp0_int_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the CP0 interrupt rules.
module tb_cp0_int_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  hw_int = 6'd0;
    logic [31:0] cur_pc = 32'd0;
    logic        pc_valid = 1'b0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = 5'd0;
    logic [31:0] cp0_wdata = 32'd0;
    logic        eret = 1'b0;
    logic [31:0] cp0_rdata;
    logic        pcint;
    logic [31:0] epc;
    logic        exl;
    logic [31:0] int_vector;

    int n_assert = 0;
    int n_fail   = 0;

    cp0_int_ctrl dut (
        .clk(clk), .rst(rst), .hw_int(hw_int), .cur_pc(cur_pc),
        .pc_valid(pc_valid), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .eret(eret), .cp0_rdata(cp0_rdata),
        .pcint(pcint), .epc(epc), .exl(exl), .int_vector(int_vector)
    );

    always #10 clk = ~clk;

    // Behavioural model: architectural registers plus two flags saying whether
    // an interrupt is being signalled this cycle and whether the handler runs.
    logic [5:0]  m_im = 6'd0, m_ip = 6'd0;
    logic        m_ie = 1'b0, m_exl = 1'b0;
    logic [31:0] m_epc = 32'd0;
    logic        m_signal = 1'b0, m_in_handler = 1'b0;
    logic [31:0] m_count = 32'd0, m_cmp = 32'd0;
    logic        m_tflag = 1'b0;
    logic        mchk = 1'b0;

    function automatic logic [5:0] m_ip_eff();
`ifdef CP0_COUNT_EN
        logic hit = (m_count == m_cmp) && (m_cmp != 32'd0);
        return {m_ip[5] | m_tflag | hit, m_ip[4:0]};
`else
        return m_ip;
`endif
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12: return {16'd0, m_im, 8'd0, m_exl, m_ie};
            5'd13: return {16'd0, m_ip_eff(), 10'd0};
            5'd14: return m_epc;
            5'd15: return 32'h00018000;
`ifdef CP0_COUNT_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: check outputs against the model at the falling edge, then
    // advance the model across the rising edge with the same inputs.
    task automatic tick();
        logic        want_int, take;
        logic        wr;
        @(negedge clk);
        if (mchk) begin
            chk("m_pcint", {31'd0, pcint}, {31'd0, m_signal});
            chk("m_epc", epc, m_epc);
            chk("m_exl", {31'd0, exl}, {31'd0, m_exl});
            chk("m_rdata", cp0_rdata, model_rd(cp0_addr));
        end
        want_int = (|(m_ip_eff() & m_im)) && m_ie && !m_exl;
        take     = want_int && pc_valid && !m_signal && !m_in_handler;
        @(posedge clk);
        if (rst) begin
            m_im = 0; m_ip = 0; m_ie = 0; m_exl = 0; m_epc = 0;
            m_signal = 0; m_in_handler = 0; m_count = 0; m_cmp = 0; m_tflag = 0;
        end else begin
            wr = cp0_we && cp0_addr == 5'd12;
            if (wr) begin
                m_im = cp0_wdata[15:10]; m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1];
            end
            if (eret) m_exl = 1'b0;
            if (take) m_exl = 1'b1;
            if (take) m_epc = cur_pc;
            else if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata;
            if (m_signal) m_in_handler = 1'b1;
            else if (m_in_handler && eret) m_in_handler = 1'b0;
            m_signal = take;
`ifdef CP0_COUNT_EN
            if (cp0_we && cp0_addr == 5'd11) m_tflag = 1'b0;
            else if (m_count == m_cmp && m_cmp != 0) m_tflag = 1'b1;
            if (cp0_we && cp0_addr == 5'd11) m_cmp = cp0_wdata;
            m_count = (cp0_we && cp0_addr == 5'd9) ? cp0_wdata : m_count + 1;
`endif
            m_ip = hw_int;
        end
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] expv);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, expv);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        tick();
        cp0_we = 1'b0;
    endtask

    task automatic leave();
        hw_int = 6'd0; pc_valid = 1'b0;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        int first_pc;
        // Reset and register defaults
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mchk = 1'b1;
        rd_chk("prid", 5'd15, 32'h00018000);
        rd_chk("status_rst", 5'd12, 32'd0);
        rd_chk("cause_rst", 5'd13, 32'd0);
        rd_chk("epc_rst", 5'd14, 32'd0);
        chk("pcint_rst", {31'd0, pcint}, 32'd0);
        chk("int_vector", int_vector, 32'h00003008);

        // Basic take: IM0 + IE, line 0 high, pipeline ready
        hw_int = 6'b000001; pc_valid = 1'b1; cur_pc = 32'h00003040;
        mtc0(5'd12, 32'h00000401);
        tick();
        chk("take_pcint", {31'd0, pcint}, 32'd1);
        chk("take_epc", epc, 32'h00003040);
        rd_chk("take_status", 5'd12, 32'h00000403);

        // Handler with line held: no nested interrupt, then eret re-arms
        tick();
        chk("hdl_pcint0", {31'd0, pcint}, 32'd0);
        tick(); tick();
        chk("hdl_pcint1", {31'd0, pcint}, 32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret_exl", {31'd0, exl}, 32'd0);
        chk("eret_nopcint", {31'd0, pcint}, 32'd0);
        tick();
        chk("eret_retake", {31'd0, pcint}, 32'd1);
        leave();

        // Stalled pipeline: wait for pc_valid
        hw_int = 6'b000001; pc_valid = 1'b0; cur_pc = 32'h00001111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_nopcint", {31'd0, pcint}, 32'd0);
        end
        pc_valid = 1'b1; cur_pc = 32'h00002222;
        tick();
        chk("stall_pcint", {31'd0, pcint}, 32'd1);
        chk("stall_epc", epc, 32'h00002222);
        leave();

        // mtc0 EPC in the entry cycle loses to the hardware PC
        hw_int = 6'b000001; pc_valid = 1'b0;
        tick();
        pc_valid = 1'b1; cur_pc = 32'h00004444;
        mtc0(5'd14, 32'hDEADBEEF);
        chk("epc_hw_wins", epc, 32'h00004444);
        leave();

        // mtc0 Status in the entry cycle: IM/IE written, EXL forced
        hw_int = 6'b000001; pc_valid = 1'b0;
        tick();
        pc_valid = 1'b1; cur_pc = 32'h00005555;
        mtc0(5'd12, 32'h00000C01);
        rd_chk("status_forced_exl", 5'd12, 32'h00000C03);
        chk("status_entry_pcint", {31'd0, pcint}, 32'd1);

        // Reset while signalling the interrupt
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_take_pcint", {31'd0, pcint}, 32'd0);
        chk("rst_take_epc", epc, 32'd0);
        rd_chk("rst_take_status", 5'd12, 32'd0);
        hw_int = 6'd0;

        // Pending in WAIT, then masked off by software
        pc_valid = 1'b0;
        mtc0(5'd12, 32'h00000401);
        hw_int = 6'b000001;
        tick(); tick();
        mtc0(5'd12, 32'h00000000);
        pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_cancel", {31'd0, pcint}, 32'd0);
        end
        rd_chk("wait_status", 5'd12, 32'd0);
        hw_int = 6'd0;
        tick();

`ifdef CP0_COUNT_EN
        // Timer interrupt through IP7
        pc_valid = 1'b1;
        mtc0(5'd12, 32'h00008001);
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        first_pc = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pcint && first_pc < 0) first_pc = i;
        end
        chk("timer_latency", first_pc, 32'd11);
        rd_chk("timer_ip7", 5'd13, 32'h00008000);
        mtc0(5'd11, 32'd0);
        rd_chk("timer_clear", 5'd13, 32'd0);
        leave();
        mtc0(5'd12, 32'd0);
`else
        first_pc = 0;
        mtc0(5'd9, 32'h12345678);
        mtc0(5'd11, 32'h00000010);
        rd_chk("count_absent", 5'd9, 32'd0);
        rd_chk("compare_absent", 5'd11, 32'd0);
        chk("no_timer_pcint", {31'd0, pcint}, first_pc);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            hw_int   = 6'($urandom);
            pc_valid = ($urandom % 4) != 0;
            cur_pc   = $urandom & 32'hFFFF_FFFC;
            eret     = ($urandom % 8) == 0;
            a        = 5'($urandom % 32);
            if (a == 5'd9 || a == 5'd11) a = 5'd12;
            cp0_we   = ($urandom % 5) == 0;
            cp0_addr = cp0_we ? a : 5'($urandom % 32);
            if (cp0_we && a == 5'd12)
                cp0_wdata = ($urandom & 32'h0000FC00) | (($urandom % 4 == 0) ? 32'h2 : 32'h0) | 32'h1;
            else
                cp0_wdata = $urandom;
            tick();
        end
        cp0_we = 1'b0; eret = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
